// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// default timing constants for a 1 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } btn_state_e;

    localparam int unsigned DefDebounceCycles = 10000;   // 10 ms
    localparam int unsigned DefRepeatDelay    = 500000;  // 500 ms
    localparam int unsigned DefRepeatPeriod   = 100000;  // 100 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce counter and press/auto-repeat pulse FSM.
// Auto-repeat (DELAY/REPEAT states and timer) exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter int unsigned RepeatDelay    = DefRepeatDelay,
    parameter int unsigned RepeatPeriod   = DefRepeatPeriod
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

    if (DebounceCycles < 2 || RepeatDelay < 2 || RepeatPeriod < 2) begin : g_bad_cfg
        $error("btn_channel: timing parameters must all be >= 2");
    end

    logic [1:0]      sync_q;
    logic            sync_pressed;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            toggle, rise, fall;
    logic            pulse_q;

    assign sync_pressed = ~sync_q[1];

    always_comb begin
        cnt_d  = '0;
        toggle = 1'b0;
        if (sync_pressed != level_q) begin
            if (cnt_q == CntW'(DebounceCycles - 1)) begin
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_d = level_q ^ toggle;
    assign rise    = toggle & ~level_q;
    assign fall    = toggle & level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned TmrW = $clog2(max_u(RepeatDelay, RepeatPeriod) + 1);

    btn_state_e      state_q;
    logic [TmrW-1:0] tmr_q;

    // Timer holds 1 on the cycle after a pulse, so a match at N lands the next pulse N edges later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        pulse_q <= 1'b1;
                        tmr_q   <= TmrW'(1);
                        state_q <= StDelay;
                    end
                end
                StDelay: begin
                    if (fall) begin
                        tmr_q   <= '0;
                        state_q <= StIdle;
                    end else if (tmr_q == TmrW'(RepeatDelay)) begin
                        pulse_q <= 1'b1;
                        tmr_q   <= TmrW'(1);
                        state_q <= StRepeat;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (fall) begin
                        tmr_q   <= '0;
                        state_q <= StIdle;
                    end else if (tmr_q == TmrW'(RepeatPeriod)) begin
                        pulse_q <= 1'b1;
                        tmr_q   <= TmrW'(1);
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: begin
                    tmr_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= rise;
        end
    end
`endif

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_debounce_repeat.sv
// Multi-channel push-button conditioner: one independent btn_channel per button.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat pulses while a button is held.
module btn_debounce_repeat
    import btn_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
    parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_n_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] pulse_out
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        btn_channel #(
            .DebounceCycles(DEBOUNCE_CYCLES),
            .RepeatDelay   (REPEAT_DELAY),
            .RepeatPeriod  (REPEAT_PERIOD)
        ) u_ch (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .btn_n_i(btn_n_in[i]),
            .level_o(level_out[i]),
            .pulse_o(pulse_out[i])
        );
    end

endmodule
